// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU: ALU commands, ISA opcodes and
// the control sequencer state type.
package cpu_pkg;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_INC   = 3'b001;
   localparam logic [2:0] ALU_NEG   = 3'b010;
   localparam logic [2:0] ALU_SUB   = 3'b011;
   localparam logic [2:0] ALU_PASSA = 3'b100;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_NEG   = 4'h5;
   localparam logic [3:0] OP_INC   = 4'h6;
   localparam logic [3:0] OP_JMP   = 4'h7;
   localparam logic [3:0] OP_JZ    = 4'h8;
   localparam logic [3:0] OP_JN    = 4'h9;
   localparam logic [3:0] OP_HALT  = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_MEM_RD = 3'd2,
      ST_MEM_WR = 3'd3,
      ST_EXEC   = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

endpackage

// File: rtl/cpu_control.sv
// Multicycle control sequencer for the accumulator CPU: registered state and
// condition flags, with all datapath/memory strobes decoded combinationally.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_FETCH  | read instruction at PC; IR load + PC increment on mem_ready
// ST_DECODE | one cycle; dispatch on opcode, resolve jumps
// ST_MEM_RD | read operand at IR address into MDR
// ST_MEM_WR | write AC to IR address
// ST_EXEC   | ALU operation, AC load, flag capture
// ST_HALT   | absorbing until reset
module cpu_control
   import cpu_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_ir_opcode,
   input  logic       i_mem_ready,
   input  logic       i_alu_zero,
   input  logic       i_alu_neg,
   output logic [2:0] o_alu_op,
   output logic       o_alu_a_sel,
   output logic       o_mem_req,
   output logic       o_mem_we,
   output logic       o_mem_addr_sel,
   output logic       o_ir_load,
   output logic       o_mdr_load,
   output logic       o_ac_load,
   output logic       o_pc_inc,
   output logic       o_pc_load,
   output logic       o_flag_z,
   output logic       o_flag_n,
   output logic       o_halted,
   output logic       o_illegal
);

   state_t     r_state;
   logic       r_flag_z;
   logic       r_flag_n;
   logic       r_halted;
   logic       r_illegal;

   state_t     w_state_nxt;
   logic [2:0] w_alu_op;
   logic       w_alu_a_sel;
   logic       w_mem_req;
   logic       w_mem_we;
   logic       w_mem_addr_sel;
   logic       w_ir_load;
   logic       w_mdr_load;
   logic       w_ac_load;
   logic       w_pc_inc;
   logic       w_pc_load;
   logic       w_set_illegal;

   // Reset gates the whole decode so an in-flight request is dropped without
   // a completion strobe, even if mem_ready arrives in the reset cycle.
   always_comb begin
      w_state_nxt    = r_state;
      w_alu_op       = ALU_PASSA;
      w_alu_a_sel    = 1'b0;
      w_mem_req      = 1'b0;
      w_mem_we       = 1'b0;
      w_mem_addr_sel = 1'b0;
      w_ir_load      = 1'b0;
      w_mdr_load     = 1'b0;
      w_ac_load      = 1'b0;
      w_pc_inc       = 1'b0;
      w_pc_load      = 1'b0;
      w_set_illegal  = 1'b0;
      if (!i_reset) begin
         case (r_state)
            ST_FETCH: begin
               w_mem_req = 1'b1;
               if (i_mem_ready) begin
                  w_ir_load   = 1'b1;
                  w_pc_inc    = 1'b1;
                  w_state_nxt = ST_DECODE;
               end
            end
            ST_DECODE: begin
               case (i_ir_opcode)
                  OP_LOAD, OP_ADD, OP_SUB: w_state_nxt = ST_MEM_RD;
                  OP_STORE:                w_state_nxt = ST_MEM_WR;
                  OP_NOP, OP_NEG, OP_INC:  w_state_nxt = ST_EXEC;
                  OP_JMP: begin
                     w_pc_load   = 1'b1;
                     w_state_nxt = ST_FETCH;
                  end
                  OP_JZ: begin
                     w_pc_load   = r_flag_z;
                     w_state_nxt = ST_FETCH;
                  end
                  OP_JN: begin
                     w_pc_load   = r_flag_n;
                     w_state_nxt = ST_FETCH;
                  end
                  OP_HALT: w_state_nxt = ST_HALT;
                  default: begin
                     w_set_illegal = 1'b1;
                     w_state_nxt   = ST_HALT;
                  end
               endcase
            end
            ST_MEM_RD: begin
               w_mem_req      = 1'b1;
               w_mem_addr_sel = 1'b1;
               if (i_mem_ready) begin
                  w_mdr_load  = 1'b1;
                  w_state_nxt = ST_EXEC;
               end
            end
            ST_MEM_WR: begin
               // ALU passes AC through so the write data path is AC.
               w_mem_req      = 1'b1;
               w_mem_we       = 1'b1;
               w_mem_addr_sel = 1'b1;
               w_alu_op       = ALU_PASSA;
               w_alu_a_sel    = 1'b0;
               if (i_mem_ready) begin
                  w_state_nxt = ST_FETCH;
               end
            end
            ST_EXEC: begin
               w_state_nxt = ST_FETCH;
               case (i_ir_opcode)
                  OP_LOAD: begin
                     w_alu_op    = ALU_PASSA;
                     w_alu_a_sel = 1'b1;
                     w_ac_load   = 1'b1;
                  end
                  OP_ADD: begin
                     w_alu_op    = ALU_ADD;
                     w_alu_a_sel = 1'b1;
                     w_ac_load   = 1'b1;
                  end
                  OP_SUB: begin
                     w_alu_op    = ALU_SUB;
                     w_alu_a_sel = 1'b1;
                     w_ac_load   = 1'b1;
                  end
                  OP_NEG: begin
                     w_alu_op    = ALU_NEG;
                     w_alu_a_sel = 1'b0;
                     w_ac_load   = 1'b1;
                  end
                  OP_INC: begin
                     w_alu_op    = ALU_INC;
                     w_alu_a_sel = 1'b0;
                     w_ac_load   = 1'b1;
                  end
                  default: begin
                     w_ac_load = 1'b0;
                  end
               endcase
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_FETCH;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_FETCH;
         r_flag_z  <= 1'b0;
         r_flag_n  <= 1'b0;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_halted <= (w_state_nxt == ST_HALT);
         if (w_ac_load) begin
            r_flag_z <= i_alu_zero;
            r_flag_n <= i_alu_neg;
         end
         if (w_set_illegal) begin
            r_illegal <= 1'b1;
         end
      end
   end

   assign o_alu_op       = w_alu_op;
   assign o_alu_a_sel    = w_alu_a_sel;
   assign o_mem_req      = w_mem_req;
   assign o_mem_we       = w_mem_we;
   assign o_mem_addr_sel = w_mem_addr_sel;
   assign o_ir_load      = w_ir_load;
   assign o_mdr_load     = w_mdr_load;
   assign o_ac_load      = w_ac_load;
   assign o_pc_inc       = w_pc_inc;
   assign o_pc_load      = w_pc_load;
   assign o_flag_z       = r_flag_z;
   assign o_flag_n       = r_flag_n;
   assign o_halted       = r_halted;
   assign o_illegal      = r_illegal;

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: instruction-level reference model with
// randomized opcodes, memory wait states and ALU flags.
module tb_cpu_control;
   import cpu_pkg::*;

   logic       clk;
   logic       reset;
   logic [3:0] ir_opcode;
   logic       mem_ready;
   logic       alu_zero;
   logic       alu_neg;
   logic [2:0] alu_op;
   logic       alu_a_sel, mem_req, mem_we, mem_addr_sel;
   logic       ir_load, mdr_load, ac_load, pc_inc, pc_load;
   logic       flag_z, flag_n, halted, illegal;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: condition flags as the ISA defines them.
   logic m_z = 1'b0;
   logic m_n = 1'b0;

   // Output snapshot taken mid-cycle by cyc().
   logic [2:0] s_alu_op;
   logic       s_a_sel, s_req, s_we, s_addr, s_ir, s_mdr, s_ac, s_pci, s_pcl;

   cpu_control dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_ir_opcode    (ir_opcode),
      .i_mem_ready    (mem_ready),
      .i_alu_zero     (alu_zero),
      .i_alu_neg      (alu_neg),
      .o_alu_op       (alu_op),
      .o_alu_a_sel    (alu_a_sel),
      .o_mem_req      (mem_req),
      .o_mem_we       (mem_we),
      .o_mem_addr_sel (mem_addr_sel),
      .o_ir_load      (ir_load),
      .o_mdr_load     (mdr_load),
      .o_ac_load      (ac_load),
      .o_pc_inc       (pc_inc),
      .o_pc_load      (pc_load),
      .o_flag_z       (flag_z),
      .o_flag_n       (flag_n),
      .o_halted       (halted),
      .o_illegal      (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at posedge+1: drive inputs, sample at negedge, return at next posedge+1.
   task automatic cyc(input logic rdy, input logic z, input logic n);
      mem_ready = rdy;
      alu_zero  = z;
      alu_neg   = n;
      @(negedge clk);
      s_alu_op = alu_op;
      s_a_sel  = alu_a_sel;
      s_req    = mem_req;
      s_we     = mem_we;
      s_addr   = mem_addr_sel;
      s_ir     = ir_load;
      s_mdr    = mdr_load;
      s_ac     = ac_load;
      s_pci    = pc_inc;
      s_pcl    = pc_load;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int ncyc);
      int bad;
      bad = 0;
      reset = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         cyc(1'b1, 1'(urand01()), 1'(urand01()));
         if (s_req || s_we || s_addr || s_ir || s_mdr || s_ac || s_pci || s_pcl ||
             s_a_sel || s_alu_op != ALU_PASSA)
            bad++;
      end
      reset = 1'b0;
      m_z = 1'b0;
      m_n = 1'b0;
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL reset_outputs_inactive: %0d active cycles, required 0", bad);
      end
      n_vec++;
      if ({halted, illegal, flag_z, flag_n} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_regs: halted/illegal/z/n=%b required 0000",
                  {halted, illegal, flag_z, flag_n});
      end
   endtask

   function automatic int urand01();
      return int'($urandom_range(0, 1));
   endfunction

   // Runs one legal non-HALT instruction starting in FETCH. w1/w2 are the
   // wait cycles for the fetch and operand accesses; zx/nx are the ALU flags
   // presented during the execute cycle.
   task automatic run_instr(input logic [3:0] op, input int w1, input int w2,
                            input logic zx, input logic nx, input string tag);
      bit   is_rd, is_wr, is_ex, wr_ac;
      int   n_fetch, n_mem, total, phase_end;
      int   c_req, c_addr, c_we, c_ir, c_pci, c_mdr, c_ac, c_pcl, bad_strobe, bad_wr;
      logic [2:0] ac_op, exp_op;
      logic ac_sel, exp_sel, rdy, z, n, start_ok;
      int   exp_pcl;

      is_rd   = (op == OP_LOAD || op == OP_ADD || op == OP_SUB);
      is_wr   = (op == OP_STORE);
      is_ex   = is_rd || op == OP_NOP || op == OP_NEG || op == OP_INC;
      wr_ac   = is_ex && op != OP_NOP;
      n_fetch = w1 + 1;
      n_mem   = (is_rd || is_wr) ? w2 + 1 : 0;
      total   = n_fetch + 1 + n_mem + (is_ex ? 1 : 0);
      phase_end = n_fetch + n_mem;
      exp_pcl = (op == OP_JMP || (op == OP_JZ && m_z) || (op == OP_JN && m_n)) ? 1 : 0;
      c_req = 0; c_addr = 0; c_we = 0; c_ir = 0; c_pci = 0; c_mdr = 0;
      c_ac = 0; c_pcl = 0; bad_strobe = 0; bad_wr = 0;
      ac_op = 3'b111; ac_sel = 1'b0; start_ok = 1'b0;
      ir_opcode = op;

      for (int k = 0; k < total; k++) begin
         if (k < n_fetch)       rdy = (k == n_fetch - 1);
         else if (k == n_fetch) rdy = 1'(urand01());
         else if (k <= phase_end) rdy = (k == phase_end);
         else                   rdy = 1'(urand01());
         if (k == total - 1 && is_ex) begin
            z = zx; n = nx;
         end else begin
            z = 1'(urand01()); n = 1'(urand01());
         end
         cyc(rdy, z, n);
         if (k == 0) start_ok = s_req && !s_addr && !s_we;
         c_req  += int'(s_req);
         c_addr += int'(s_addr);
         c_we   += int'(s_we);
         c_ir   += int'(s_ir);
         c_pci  += int'(s_pci);
         c_mdr  += int'(s_mdr);
         c_pcl  += int'(s_pcl);
         if ((s_ir || s_pci || s_mdr) && !rdy) bad_strobe++;
         if (s_we && (s_alu_op != ALU_PASSA || s_a_sel)) bad_wr++;
         if (s_ac) begin
            c_ac++;
            ac_op  = s_alu_op;
            ac_sel = s_a_sel;
         end
      end

      if (wr_ac) begin
         m_z = zx;
         m_n = nx;
      end
      case (op)
         OP_ADD:  begin exp_op = ALU_ADD;   exp_sel = 1'b1; end
         OP_SUB:  begin exp_op = ALU_SUB;   exp_sel = 1'b1; end
         OP_NEG:  begin exp_op = ALU_NEG;   exp_sel = 1'b0; end
         OP_INC:  begin exp_op = ALU_INC;   exp_sel = 1'b0; end
         default: begin exp_op = ALU_PASSA; exp_sel = 1'b1; end
      endcase

      n_vec++;
      if (!start_ok) begin
         n_err++;
         $display("FAIL %s op%0h fetch_start: req=%b addr=%b we=%b required 1,0,0",
                  tag, op, mem_req, mem_addr_sel, mem_we);
      end
      n_vec++;
      if (c_ir !== 1 || c_pci !== 1) begin
         n_err++;
         $display("FAIL %s op%0h ir_load/pc_inc counts: %0d/%0d required 1/1", tag, op, c_ir, c_pci);
      end
      n_vec++;
      if (c_mdr !== int'(is_rd)) begin
         n_err++;
         $display("FAIL %s op%0h mdr_load count: %0d required %0d", tag, op, c_mdr, int'(is_rd));
      end
      n_vec++;
      if (c_ac !== int'(wr_ac)) begin
         n_err++;
         $display("FAIL %s op%0h ac_load count: %0d required %0d", tag, op, c_ac, int'(wr_ac));
      end
      n_vec++;
      if (c_pcl !== exp_pcl) begin
         n_err++;
         $display("FAIL %s op%0h pc_load count: %0d required %0d", tag, op, c_pcl, exp_pcl);
      end
      n_vec++;
      if (c_req !== n_fetch + n_mem || c_addr !== n_mem || c_we !== (is_wr ? n_mem : 0)) begin
         n_err++;
         $display("FAIL %s op%0h mem cycles req/addr/we: %0d/%0d/%0d required %0d/%0d/%0d",
                  tag, op, c_req, c_addr, c_we, n_fetch + n_mem, n_mem, is_wr ? n_mem : 0);
      end
      n_vec++;
      if (bad_strobe !== 0 || bad_wr !== 0) begin
         n_err++;
         $display("FAIL %s op%0h strobe_timing: early=%0d bad_wr=%0d required 0/0",
                  tag, op, bad_strobe, bad_wr);
      end
      if (wr_ac) begin
         n_vec++;
         if (ac_op !== exp_op || ac_sel !== exp_sel) begin
            n_err++;
            $display("FAIL %s op%0h exec alu_op/a_sel: %b/%b required %b/%b",
                     tag, op, ac_op, ac_sel, exp_op, exp_sel);
         end
      end
      n_vec++;
      if (flag_z !== m_z || flag_n !== m_n || halted !== 1'b0 || illegal !== 1'b0) begin
         n_err++;
         $display("FAIL %s op%0h flags z/n/halt/ill: %b%b%b%b required %b%b00",
                  tag, op, flag_z, flag_n, halted, illegal, m_z, m_n);
      end
   endtask

   task automatic test_reset();
      ir_opcode = OP_NOP;
      do_reset(3);
      cyc(1'b1, 1'b0, 1'b0);
      n_vec++;
      if (s_req !== 1'b1 || s_addr !== 1'b0) begin
         n_err++;
         $display("FAIL first_cycle_after_reset: req=%b addr=%b required 1,0", s_req, s_addr);
      end
      do_reset(1);
   endtask

   task automatic test_load_wait();
      run_instr(OP_LOAD, 0, 2, 1'b0, 1'b1, "load_wait");
   endtask

   task automatic test_flags_jump();
      run_instr(OP_SUB, 1, 0, 1'b1, 1'b0, "sub_zero");
      run_instr(OP_JZ, 0, 0, 1'b0, 1'b0, "jz_taken");
      run_instr(OP_JN, 0, 0, 1'b0, 1'b0, "jn_not_taken");
   endtask

   task automatic test_store();
      run_instr(OP_NEG, 0, 0, 1'b0, 1'b1, "neg_pre");
      run_instr(OP_STORE, 0, 0, 1'b1, 1'b0, "store");
      run_instr(OP_STORE, 2, 3, 1'b1, 1'b0, "store_wait");
   endtask

   task automatic test_halt(input logic [3:0] op, input logic exp_ill);
      int bad;
      bad = 0;
      ir_opcode = op;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      n_vec++;
      if (halted !== 1'b1 || illegal !== exp_ill) begin
         n_err++;
         $display("FAIL halt_op%0h halted/illegal: %b/%b required 1/%b", op, halted, illegal, exp_ill);
      end
      for (int i = 0; i < 5; i++) begin
         ir_opcode = 4'($urandom_range(0, 15));
         cyc(1'b1, 1'(urand01()), 1'(urand01()));
         if (s_req || s_ir || s_mdr || s_ac || s_pci || s_pcl || !halted) bad++;
      end
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL halt_op%0h absorbing: %0d bad cycles required 0", op, bad);
      end
      do_reset(1);
   endtask

   task automatic test_reset_mid();
      ir_opcode = OP_LOAD;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      cyc(1'b1, 1'b0, 1'b0);
      reset = 1'b0;
      m_z = 1'b0;
      m_n = 1'b0;
      n_vec++;
      if (s_mdr !== 1'b0 || s_req !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_rd: mdr_load=%b req=%b required 0,0", s_mdr, s_req);
      end
      // Stay in FETCH for one wait cycle; run_instr then finishes this fetch.
      cyc(1'b0, 1'b0, 1'b0);
      n_vec++;
      if (s_req !== 1'b1 || s_addr !== 1'b0 || s_we !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_restart: req=%b addr=%b we=%b required 1,0,0", s_req, s_addr, s_we);
      end
      run_instr(OP_INC, 0, 0, 1'b0, 1'b0, "after_reset_mid");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         run_instr(4'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'(urand01()), 1'(urand01()), "random");
      end
      for (int i = 0; i < 20; i++) begin
         run_instr(4'($urandom_range(0, 9)), 0, 0, 1'(urand01()), 1'(urand01()), "zero_wait");
      end
   endtask

   initial begin
      reset     = 1'b1;
      ir_opcode = OP_NOP;
      mem_ready = 1'b0;
      alu_zero  = 1'b0;
      alu_neg   = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_load_wait();
      test_flags_jump();
      test_store();
      test_halt(4'hB, 1'b1);
      test_halt(OP_HALT, 1'b0);
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_control.md
# cpu_control

Multicycle control sequencer for the accumulator CPU. Takes the instruction opcode field and the ALU `zero`/`neg` flags, and produces the ALU opcode, the datapath load and select strobes, and the memory request handshake. It drives the ALU's command inputs and consumes its status outputs. It sits between the instruction register and the datapath (AC, MDR, PC, ALU).

## Interface
- No parameters; all encodings come from `cpu_pkg`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ir_opcode`  in  4  opcode field of the IR; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `alu_zero`  in  1  ALU zero flag, combinational from the current ALU inputs.
- `alu_neg`  in  1  ALU negative flag (bit 31 of the result).
- `alu_op`  out  3  ALU command: ADD 000, INC 001, NEG 010, SUB 011, PASSA 100.
- `alu_a_sel`  out  1  ALU A operand: 0 = AC, 1 = MDR. ALU B is always AC.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `mem_addr_sel`  out  1  memory address: 0 = PC, 1 = IR address field.
- `ir_load`, `mdr_load`, `ac_load`, `pc_inc`, `pc_load`  out  1 each  datapath strobes.
- `flag_z`, `flag_n`  out  1 each  registered condition flags.
- `halted`  out  1  HALT state reached.
- `illegal`  out  1  sticky; set by an undefined opcode.

## Operation
- ISA opcodes: NOP 0, LOAD 1, STORE 2, ADD 3, SUB 4, NEG 5, INC 6, JMP 7, JZ 8, JN 9, HALT F. Opcodes A–E are illegal.
- States: FETCH, DECODE, MEM_RD, MEM_WR, EXEC, HALT. Reset enters FETCH.
- Outputs are decoded combinationally from state, `ir_opcode` and `mem_ready`. Default values: all strobes 0, `alu_op`=PASSA, `alu_a_sel`=0.
- FETCH:
  - Drive `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0.
  - Stay in FETCH while `mem_ready`=0.
  - In the `mem_ready` cycle, pulse `ir_load` and `pc_inc`, then go to DECODE.
- DECODE (always 1 cycle):
  - LOAD, ADD, SUB → MEM_RD.
  - STORE → MEM_WR.
  - NOP, NEG, INC → EXEC.
  - JMP: `pc_load`=1, → FETCH.
  - JZ / JN: `pc_load`=`flag_z` / `flag_n`, → FETCH.
  - HALT → HALT.
  - Illegal: set `illegal`, → HALT.
- MEM_RD:
  - Drive `mem_req`=1, `mem_addr_sel`=1.
  - On `mem_ready`, pulse `mdr_load`, → EXEC.
- MEM_WR:
  - Drive `mem_req`=1, `mem_we`=1, `mem_addr_sel`=1, `alu_op`=PASSA, `alu_a_sel`=0, so the write data is AC.
  - On `mem_ready`, → FETCH.
- EXEC:
  - `ac_load`=1 except for NOP.
  - LOAD: PASSA with a_sel=1.
  - ADD: ADD, a_sel=1.
  - SUB: SUB, a_sel=1 (AC − MDR).
  - NEG: NEG, a_sel=0.
  - INC: INC.
  - Always → FETCH.
- Flags: on any cycle with `ac_load`=1, capture `flag_z`<=`alu_zero` and `flag_n`<=`alu_neg`. Otherwise hold. STORE, jumps and NOP leave the flags unchanged.
- HALT: absorbing until `reset`; `halted`=1 and all strobes 0.

## Timing
- Reset values:
  - State FETCH; `flag_z`, `flag_n`, `halted`, `illegal` = 0.
  - While `reset`=1, every combinational output is forced inactive: strobes 0, `mem_req` 0, `alu_op`=PASSA, selects 0.
- First cycle after `reset` falls: `mem_req`=1.
- Handshake:
  - `mem_req` stays high from state entry through the `mem_ready` cycle inclusive, and is low the following cycle unless the next state also requests.
  - `mem_ready` is ignored when `mem_req`=0.
  - `mem_we` and `mem_addr_sel` are stable for the whole request.
- Instruction latency with zero-wait memory (`mem_ready` tied 1): JMP/JZ/JN/HALT 2 cycles, NOP/NEG/INC/STORE 3, LOAD/ADD/SUB 4. Add one cycle per wait cycle.
- Reset mid-request: the request is abandoned, with no completion strobe in the reset cycle. A `mem_ready` arriving in the reset cycle has no effect.
- Flags written in EXEC are visible to a JZ/JN in the next instruction's DECODE.

## Structure
- `cpu_pkg` holds:
  - ALU opcode localparams (shared with the ALU).
  - ISA opcode localparams.
  - State encoding.
- One module: `cpu_control`, with a registered state and flags plus one combinational output decode. No sub-module.

## Test plan
- Reset held 3 cycles, then released with `mem_ready`=1 → all strobes 0 during reset; first cycle after release `mem_req`=1, `mem_addr_sel`=0.
- LOAD (1) with `mem_ready` low for 2 cycles in MEM_RD → `mdr_load` only in the ready cycle. EXEC shows `alu_op`=100, `alu_a_sel`=1, `ac_load`=1. Total 6 cycles.
- SUB with `alu_zero`=1, `alu_neg`=0 in EXEC, followed by JZ → `flag_z`=1, and `pc_load`=1 in the JZ DECODE cycle. Follow with JN → `pc_load`=0.
- STORE (2) with zero-wait memory → one MEM_WR cycle with `mem_we`=1, `alu_op`=100, `alu_a_sel`=0. Flags unchanged; 3 cycles.
- Opcode B → `illegal`=1 and `halted`=1 from the cycle after DECODE. No further `mem_req` until reset; reset clears both flags.
- `reset` asserted in MEM_RD with `mem_ready`=1 in the same cycle → no `mdr_load`; FETCH restarts after reset falls.
